store_align_buffer: RTL and testbench
=====================================

# store_align_buffer

Parametrised store-path unit between execute and the data-memory port. It turns register-sourced store data (sb/sh/sw, plus sd when DATA_W=64) into lane-aligned write data and byte enables. Accepted stores are queued in a DEPTH-entry FIFO, and stores that cross a memory-word boundary are split into two back-to-back memory writes. Every memory write is held until `mem_resp`.

## Interface
- DATA_W, 32: memory word / register width in bits; 32 or 64.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- ADDR_W, 32: byte-address width.
- BYTES (derived) = DATA_W/8; OFS_W (derived) = log2(BYTES).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  FIFO can accept a request (= !full).
- req_addr  in  ADDR_W  byte address of store.
- req_data  in  DATA_W  rs2 value; LSBs carry the data.
- req_funct3  in  3  000 sb, 001 sh, 010 sw, 011 sd.
- store_err  out  1  one-cycle pulse when an unsupported size is dropped.
- mem_write  out  1  write request to memory.
- mem_address  out  ADDR_W  word-aligned address (low OFS_W bits zero).
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_byte_enable  out  BYTES  active-high lane mask.
- mem_resp  in  1  memory done; completes the current beat.
- empty  out  1  FIFO empty and no beat in flight (fence/drain indicator).

## Operation
- Accept: push happens when req_valid && req_ready at a rising edge.
- Size decode: size = 1 << funct3[1:0] bytes.
- Unsupported size: funct3[2]=1, or size > BYTES. The request is still accepted (handshake completes) but is not pushed, and store_err pulses high the following cycle.
- Alignment at push:
  - ofs = addr[OFS_W-1:0]; base = addr with low OFS_W bits cleared.
  - The entry stores a 2·DATA_W shifted word = zero-extended size-byte data << (8·ofs).
  - It also stores a 2·BYTES mask = ((1<<size)-1) << ofs.
  - Bytes above `size` in req_data are ignored.
- Split: an entry needs two beats iff mask[2·BYTES-1:BYTES] != 0.
  - Lo beat: base, lo halves of data and mask.
  - Hi beat: base+BYTES, hi halves. The lo beat mask is always nonzero.
- Output FSM, states IDLE, LO, HI:
  - IDLE: FIFO not empty → LO next cycle.
  - LO: mem_write=1 with the lo beat. On mem_resp: if split → HI; else pop, then go to LO if another entry remains after the pop, otherwise IDLE.
  - HI: mem_write=1 with the hi beat. On mem_resp: pop, then go to LO or IDLE as above.
- Output stability: mem_address, mem_wdata, mem_byte_enable and mem_write are registered and stay stable while waiting for mem_resp.
- Occupancy: count 0..DEPTH; read/write pointers wrap modulo DEPTH.
- FIFO ordering: strict, with no merging or forwarding.
- Push and pop in the same cycle: allowed whenever not full; count is unchanged.
- Full: req_ready=0, even if a pop occurs in the same cycle.
- Address wrap: base+BYTES wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - FSM=IDLE, count=0, pointers=0.
  - req_ready=1, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, store_err=0, empty=1.
- Assertion of rst_n low mid-transaction: state clears immediately and asynchronously; in-flight and queued stores are discarded, and mem_write drops without waiting for mem_resp.
- Latency: a request pushed at edge N into an empty, idle unit drives mem_write=1 from edge N+1.
- Beat handshake:
  - mem_resp is sampled only while mem_write=1.
  - mem_resp high at edge M ends the beat. For a split entry the hi beat is driven from edge M, so there is no idle cycle between beats.
  - For a non-split entry, the next entry (if any) is driven from edge M.
- empty deasserts the cycle after a push and reasserts the cycle after the final mem_resp with count=0.
- Zero-wait memory: with mem_resp tied high, sustained throughput is one beat per cycle.

## Test plan
- sb, DATA_W=32, addr 0x1003, data 0xFFFF_FFAB → one beat: mem_address 0x1000, wdata 0xAB00_0000, be 4'b1000.
- sh at 0x1002, data 0x0000_1234 → address 0x1000, wdata 0x1234_0000, be 4'b1100.
- sw at 0x2001, data 0xDDCC_BBAA, mem_resp after 2 cycles per beat → beat0 at 0x2000, wdata 0xCCBB_AA00, be 4'b1110; then beat1 at 0x2004, wdata 0x0000_00DD, be 4'b0001; empty=1 after the second resp.
- DEPTH=4 with mem_resp held low, push 5 sw → req_ready=0 after the 4th push. Then 1-cycle resp pulses → FIFO drains in order and req_ready returns to 1 the cycle after the first pop.
- funct3=011 with DATA_W=32 → handshake completes, store_err pulses high for exactly 1 cycle, mem_write never asserts. With DATA_W=64, sd at 0x10 → be 8'hFF.
- Three queued stores, rst_n low mid-LO beat → mem_write=0, count=0, empty=1 with no clock edge. After release, no stale writes are issued.

Source files
------------

// File: rtl/store_align_buffer_if.sv
// Store request / memory write bundle for store_align_buffer.
// The slave side is the buffer; the master side is execute plus the memory port.
interface store_align_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [2:0]        req_funct3;
  logic              store_err;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_byte_enable;
  logic              mem_resp;
  logic              empty;

  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_resp,
    input  req_ready, store_err, mem_write, mem_address, mem_wdata,
           mem_byte_enable, empty
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, mem_resp,
    output req_ready, store_err, mem_write, mem_address, mem_wdata,
           mem_byte_enable, empty
  );
endinterface

// File: rtl/store_align_buffer.sv
// Store-path aligner: queues sb/sh/sw/sd stores as lane-aligned entries and
// issues them as one or two held memory writes (two when crossing a word).
module store_align_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  store_align_buffer_if.slave  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LO, HI} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   base;
    logic [2*DATA_W-1:0] data;
    logic [2*BYTES-1:0]  mask;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]  mem_be_q, mem_be_d;
  logic              store_err_q, store_err_d;

  logic              req_ready, accept, unsupported, push_en, pop, finish, remain;
  logic [BYTES-1:0]  size_mask;
  logic [DATA_W-1:0] data_m;
  logic [OFS_W-1:0]  ofs;
  entry_t            push_entry, head, next_e;

  assign req_ready   = (count_q != CNT_W'(DEPTH));
  assign unsupported = bus.req_funct3[2] || ((1 << bus.req_funct3[1:0]) > BYTES);
  assign accept      = bus.req_valid && req_ready;
  assign push_en     = accept && !unsupported;
  assign store_err_d = accept && unsupported;

  // Build the double-width shifted word and mask for the incoming store.
  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    size_mask = '0;
    data_m    = '0;
    for (int i = 0; i < BYTES; i++) begin
      size_mask[i]    = (i < (1 << bus.req_funct3[1:0]));
      data_m[i*8 +: 8] = size_mask[i] ? bus.req_data[i*8 +: 8] : 8'h00;
    end
    ofs             = bus.req_addr[OFS_W-1:0];
    push_entry.base = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    push_entry.data = {{DATA_W{1'b0}}, data_m} << {ofs, 3'b000};
    push_entry.mask = {{BYTES{1'b0}}, size_mask} << ofs;
  end

  assign head   = fifo_q[rd_ptr_q];
  // After popping the last queued entry, a same-cycle push is issued directly.
  assign next_e = (count_q > CNT_W'(1)) ? fifo_q[rd_ptr_q + PTR_W'(1)] : push_entry;
  assign remain = (count_q > CNT_W'(1)) || push_en;

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    finish        = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    unique case (state_q)
      IDLE: if (count_q != '0) begin
        state_d       = LO;
        mem_address_d = head.base;
        mem_wdata_d   = head.data[DATA_W-1:0];
        mem_be_d      = head.mask[BYTES-1:0];
      end
      LO: if (bus.mem_resp) begin
        if (|head.mask[2*BYTES-1:BYTES]) begin
          state_d       = HI;
          mem_address_d = head.base + ADDR_W'(BYTES);
          mem_wdata_d   = head.data[2*DATA_W-1:DATA_W];
          mem_be_d      = head.mask[2*BYTES-1:BYTES];
        end else begin
          finish = 1'b1;
        end
      end
      HI: finish = bus.mem_resp;
      default: state_d = IDLE;
    endcase
    if (finish) begin
      pop = 1'b1;
      if (remain) begin
        state_d       = LO;
        mem_address_d = next_e.base;
        mem_wdata_d   = next_e.data[DATA_W-1:0];
        mem_be_d      = next_e.mask[BYTES-1:0];
      end else begin
        state_d = IDLE;
      end
    end
    mem_write_d = (state_d != IDLE);
    count_d     = count_q + CNT_W'(push_en) - CNT_W'(pop);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      store_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_q + PTR_W'(push_en);
      rd_ptr_q      <= rd_ptr_q + PTR_W'(pop);
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      store_err_q   <= store_err_d;
    end
  end

  // NOTE: entry storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign bus.req_ready       = req_ready;
  assign bus.store_err       = store_err_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_byte_enable = mem_be_q;
  assign bus.empty           = (count_q == '0);
endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: a 32-bit and a 64-bit instance,
// hand-computed beats, FIFO full/drain, unsupported sizes and async reset.
module tb_store_align_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_align_buffer_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
  store_align_buffer_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

  store_align_buffer #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave)
  );
  store_align_buffer #(.DATA_W(64), .DEPTH(4), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(if64.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input bit w64, input logic [31:0] addr, input logic [63:0] data,
                     input logic [2:0] f3);
    if (w64) begin
      if64.req_valid = 1'b1; if64.req_addr = addr; if64.req_data = data; if64.req_funct3 = f3;
    end else begin
      if32.req_valid = 1'b1; if32.req_addr = addr; if32.req_data = data[31:0]; if32.req_funct3 = f3;
    end
  endtask

  task automatic idle();
    if32.req_valid = 1'b0;
    if64.req_valid = 1'b0;
  endtask

  task automatic set_resp(input bit w64, input logic v);
    if (w64) if64.mem_resp = v;
    else     if32.mem_resp = v;
  endtask

  // Called at a negedge with a beat expected on the bus; holds it wait_cyc
  // cycles, then answers with a one-cycle mem_resp and returns at the next negedge.
  task automatic beat(input bit w64, input string tag, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [7:0] be, input int wait_cyc);
    logic        mw;
    logic [31:0] ad;
    logic [63:0] wd;
    logic [7:0]  b;
    for (int k = 0; k <= wait_cyc; k++) begin
      mw = w64 ? if64.mem_write   : if32.mem_write;
      ad = w64 ? if64.mem_address : if32.mem_address;
      wd = w64 ? if64.mem_wdata   : {32'h0, if32.mem_wdata};
      b  = w64 ? if64.mem_byte_enable : {4'h0, if32.mem_byte_enable};
      check({tag, ".write"}, 64'(mw), 64'(1));
      check({tag, ".addr"},  64'(ad), 64'(addr));
      check({tag, ".wdata"}, wd, wdata);
      check({tag, ".be"},    64'(b),  64'(be));
      if (k < wait_cyc) @(negedge clk);
    end
    set_resp(w64, 1'b1);
    @(negedge clk);
    set_resp(w64, 1'b0);
  endtask

  initial begin
    idle();
    if32.req_addr = '0; if32.req_data = '0; if32.req_funct3 = '0; if32.mem_resp = 1'b0;
    if64.req_addr = '0; if64.req_data = '0; if64.req_funct3 = '0; if64.mem_resp = 1'b0;
    repeat (2) @(negedge clk);

    check("rst.ready", 64'(if32.req_ready), 64'(1));
    check("rst.write", 64'(if32.mem_write), 64'(0));
    check("rst.addr",  64'(if32.mem_address), 64'(0));
    check("rst.wdata", 64'(if32.mem_wdata), 64'(0));
    check("rst.be",    64'(if32.mem_byte_enable), 64'(0));
    check("rst.err",   64'(if32.store_err), 64'(0));
    check("rst.empty", 64'(if32.empty), 64'(1));
    check("rst.empty64", 64'(if64.empty), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // sb: push at edge N, beat visible from edge N+1
    put(0, 32'h1003, 64'hFFFF_FFAB, 3'b000);
    @(negedge clk); idle();
    check("sb.lat_write", 64'(if32.mem_write), 64'(0));
    check("sb.lat_empty", 64'(if32.empty), 64'(0));
    @(negedge clk);
    beat(0, "sb", 32'h1000, 64'hAB00_0000, 8'b1000, 0);
    check("sb.empty", 64'(if32.empty), 64'(1));
    check("sb.idle",  64'(if32.mem_write), 64'(0));

    put(0, 32'h1002, 64'h0000_1234, 3'b001);
    @(negedge clk); idle();
    @(negedge clk);
    beat(0, "sh", 32'h1000, 64'h1234_0000, 8'b1100, 0);

    // sw crossing a word, two wait cycles per beat
    put(0, 32'h2001, 64'hDDCC_BBAA, 3'b010);
    @(negedge clk); idle();
    @(negedge clk);
    beat(0, "sw.lo", 32'h2000, 64'hCCBB_AA00, 8'b1110, 1);
    beat(0, "sw.hi", 32'h2004, 64'h0000_00DD, 8'b0001, 1);
    check("sw.empty", 64'(if32.empty), 64'(1));
    check("sw.idle",  64'(if32.mem_write), 64'(0));

    // split beat whose hi address wraps past the top of the address space
    put(0, 32'hFFFF_FFFE, 64'h4433_2211, 3'b010);
    @(negedge clk); idle();
    @(negedge clk);
    beat(0, "wrap.lo", 32'hFFFF_FFFC, 64'h2211_0000, 8'b1100, 0);
    beat(0, "wrap.hi", 32'h0000_0000, 64'h0000_4433, 8'b0011, 0);

    // unsupported sizes: accepted, dropped, one-cycle store_err
    for (int f = 3; f <= 4; f++) begin
      put(0, 32'h40, 64'h1234_5678, 3'(f));
      check($sformatf("bad%0d.ready", f), 64'(if32.req_ready), 64'(1));
      @(negedge clk); idle();
      check($sformatf("bad%0d.err", f),   64'(if32.store_err), 64'(1));
      check($sformatf("bad%0d.write", f), 64'(if32.mem_write), 64'(0));
      check($sformatf("bad%0d.empty", f), 64'(if32.empty), 64'(1));
      @(negedge clk);
      check($sformatf("bad%0d.err_end", f), 64'(if32.store_err), 64'(0));
      check($sformatf("bad%0d.write2", f),  64'(if32.mem_write), 64'(0));
    end

    // fill to DEPTH with memory stalled, fifth request blocked
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full.ready%0d", i), 64'(if32.req_ready), 64'(1));
      put(0, 32'h3000 + 32'(4 * i), 64'(32'h1111_1111 * 32'(i + 1)), 3'b010);
      @(negedge clk);
    end
    put(0, 32'h3010, 64'h5555_5555, 3'b010);
    check("full.ready_lo", 64'(if32.req_ready), 64'(0));
    @(negedge clk);
    check("full.ready_hold", 64'(if32.req_ready), 64'(0));
    beat(0, "full.e0", 32'h3000, 64'h1111_1111, 8'hF, 0);
    check("full.ready_back", 64'(if32.req_ready), 64'(1));
    beat(0, "full.e1", 32'h3004, 64'h2222_2222, 8'hF, 0);
    idle();
    beat(0, "full.e2", 32'h3008, 64'h3333_3333, 8'hF, 0);
    beat(0, "full.e3", 32'h300C, 64'h4444_4444, 8'hF, 0);
    beat(0, "full.e4", 32'h3010, 64'h5555_5555, 8'hF, 0);
    check("full.empty", 64'(if32.empty), 64'(1));

    // asynchronous reset in the middle of a LO beat with entries queued
    for (int i = 0; i < 3; i++) begin
      put(0, 32'h4000 + 32'(4 * i), 64'h9999_9999, 3'b010);
      @(negedge clk);
    end
    idle();
    check("arst.busy", 64'(if32.mem_write), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst.write", 64'(if32.mem_write), 64'(0));
    check("arst.empty", 64'(if32.empty), 64'(1));
    check("arst.ready", 64'(if32.req_ready), 64'(1));
    check("arst.addr",  64'(if32.mem_address), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("arst.stale%0d", k), 64'(if32.mem_write), 64'(0));
      check($sformatf("arst.empty%0d", k), 64'(if32.empty), 64'(1));
    end

    // 64-bit instance: sd, sh crossing a doubleword, sw with upper bytes ignored
    put(1, 32'h10, 64'h0123_4567_89AB_CDEF, 3'b011);
    @(negedge clk); idle();
    @(negedge clk);
    beat(1, "sd", 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    check("sd.empty", 64'(if64.empty), 64'(1));
    check("sd.err",   64'(if64.store_err), 64'(0));

    put(1, 32'h0F, 64'hFFFF_FFFF_FFFF_1234, 3'b001);
    @(negedge clk); idle();
    @(negedge clk);
    beat(1, "sh64.lo", 32'h08, 64'h3400_0000_0000_0000, 8'h80, 0);
    beat(1, "sh64.hi", 32'h10, 64'h0000_0000_0000_0012, 8'h01, 0);

    put(1, 32'h1C, 64'hFFFF_FFFF_DDCC_BBAA, 3'b010);
    @(negedge clk); idle();
    @(negedge clk);
    beat(1, "sw64", 32'h18, 64'hDDCC_BBAA_0000_0000, 8'hF0, 0);
    check("sw64.empty", 64'(if64.empty), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
